// File: rtl/mul_pkg.sv
// Shared types and default sizing for the iterative multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

    localparam int MUL_WIDTH = 32;

endpackage

// File: rtl/add_cout.sv
// Combinational WIDTH-bit adder with carry out; the ALU adder stage fed by mul_seq.
module add_cout #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul_seq.sv
// Iterative shift-and-add unsigned multiplier: one adder pass per cycle, WIDTH passes per product.
// Handshakes: a transfer happens on a rising edge where valid && ready; ready never depends on valid.
module mul_seq
    import mul_pkg::*;
#(
    parameter  int WIDTH = MUL_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    mul_state_t         state;
    mul_state_t         state_next;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_c;

    // Upper half of P accumulates; the multiplier bit sits in P[0] and shifts out.
    assign add_b = p[0] ? m : '0;

    add_cout #(
        .WIDTH(WIDTH)
    ) u_add (
        .a   (p[2*WIDTH-1:WIDTH]),
        .b   (add_b),
        .sum (add_sum),
        .cout(add_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = BUSY;
            BUSY:    if (cnt == CNT_W'(WIDTH - 1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p   <= '0;
            m   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m   <= a;
                        p   <= {{WIDTH{1'b0}}, b};
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    // Carry re-enters at the top so the shifted partial product stays exact.
                    p   <= {add_c, add_sum, p[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign product   = p;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: timing/value model plus directed literal products.
module tb_mul_seq;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    mul_seq #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Accept while idle -> busy for W edges -> result held until out_ready.
    logic [2*W-1:0] exp_q[$];
    int             m_left  = 0;
    logic           m_valid = 1'b0;
    logic [2*W-1:0] m_prod  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  = 0;
            m_valid = 1'b0;
            m_prod  = '0;
            exp_q.delete();
        end else if (!m_valid && m_left == 0) begin
            if (in_valid) begin
                exp_q.push_back((2*W)'(a) * (2*W)'(b));
                m_left = W;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_prod  = exp_q.pop_front();
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    logic b2b       = 1'b0;
    int   last_done = -1;
    int   n_b2b     = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", (2*W)'(in_ready), (2*W)'(!m_valid && m_left == 0));
            check("out_valid", (2*W)'(out_valid), (2*W)'(m_valid));
            check("busy", (2*W)'(busy), (2*W)'(m_left > 0));
            if (m_left == 0) check("product", product, m_prod);
            if (b2b && out_valid && out_ready) begin
                if (last_done >= 0) check("b2b_period", (2*W)'(cyc - last_done), (2*W)'(W + 2));
                last_done = cyc;
                n_b2b++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Starts at a negedge with the block idle; returns at a negedge with it idle again.
    task automatic run_one(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [2*W-1:0] exp, input string name,
                           input bit backpressure, input bit count_busy);
        int k;
        int busy_n;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k      = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy) busy_n++;
        end while (!out_valid && k < 200);
        if (k >= 200) begin
            n_bad++;
            $display("FAIL %s_timeout: no out_valid within %0d cycles", name, k);
            return;
        end
        check({name, "_latency"}, (2*W)'(k - 1), (2*W)'(W));
        check({name, "_value"}, product, exp);
        if (count_busy) check({name, "_busy_cycles"}, (2*W)'(busy_n), (2*W)'(W));
        if (backpressure) begin
            a        = 32'hDEAD_BEEF;
            b        = 32'h0BAD_F00D;
            in_valid = 1'b1;
            repeat (10) begin
                @(negedge clk);
                check({name, "_bp_product"}, product, exp);
                check({name, "_bp_in_ready"}, (2*W)'(in_ready), '0);
                check({name, "_bp_out_valid"}, (2*W)'(out_valid), (2*W)'(1));
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_back_to_idle"}, (2*W)'(in_ready), (2*W)'(1));
        check({name, "_product_kept"}, product, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        check("rst_in_ready", (2*W)'(in_ready), (2*W)'(1));
        check("rst_out_valid", (2*W)'(out_valid), '0);
        check("rst_busy", (2*W)'(busy), '0);
        check("rst_product", product, '0);
        #11 rst = 1'b0;
        @(negedge clk);

        run_one(32'd3, 32'd5, 64'h0000_0000_0000_000F, "3x5", 1'b0, 1'b1);
        run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max", 1'b0, 1'b0);
        run_one(32'd0, 32'h1234_5678, 64'd0, "zero_a", 1'b0, 1'b0);
        run_one(32'h1234_5678, 32'd0, 64'd0, "zero_b", 1'b0, 1'b0);
        run_one(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "bp", 1'b1, 1'b0);

        // Abort mid-operation with an asynchronous reset pulse.
        a        = 32'd5;
        b        = 32'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready", (2*W)'(in_ready), (2*W)'(1));
        check("abort_out_valid", (2*W)'(out_valid), '0);
        check("abort_busy", (2*W)'(busy), '0);
        check("abort_product", product, '0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("after_abort_idle", (2*W)'(in_ready), (2*W)'(1));
        run_one(32'd7, 32'd9, 64'd63, "7x9", 1'b0, 1'b0);

        // Back-to-back random pairs with the consumer always ready.
        out_ready = 1'b1;
        b2b       = 1'b1;
        last_done = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            a        = $urandom;
            b        = $urandom;
            in_valid = 1'b1;
            t        = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) begin
                n_bad++;
                $display("FAIL b2b_accept_timeout: pair %0d not accepted", i);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((m_left != 0 || m_valid) && t < 200);
        check("b2b_results", (2*W)'(n_b2b), (2*W)'(100));
        b2b       = 1'b0;
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
